// File: rtl/i2s_clkgen.sv
// I2S / TDM bit- and frame-clock generator driven by a phase accumulator.
// bclk toggles one refclk after each accumulator carry; frame counters advance on bclk falls.
module i2s_clkgen #(
    parameter int unsigned              ACC_WIDTH   = 32,
    parameter logic [ACC_WIDTH-1:0]     DEFAULT_INC = 242442314,
    parameter int unsigned              SLOT_BITS   = 16,
    parameter int unsigned              CHANNELS    = 2,
    parameter int unsigned              MODE        = 0,
    parameter int unsigned              LOCK_CYCLES = 16,
    localparam int unsigned             SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [ACC_WIDTH-1:0] inc_in,
    input  logic                 inc_load,
    output logic                 bclk,
    output logic                 bclk_rise,
    output logic                 bclk_fall,
    output logic                 lrclk,
    output logic [SW-1:0]        slot_idx,
    output logic                 frame_start,
    output logic                 locked
);

    localparam int unsigned BW = $clog2(SLOT_BITS);
    localparam logic [SW:0] LR_HALF = (SW+1)'((CHANNELS + 1) / 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] inc_reg;
    logic                 carry_q;
    logic [BW-1:0]        bit_cnt;
    logic [7:0]           lock_cnt;

    logic [ACC_WIDTH:0]   sum;
    logic                 inc_accept;
    logic                 fall_now;
    logic                 bit_wrap;
    logic [BW-1:0]        bit_nxt;
    logic [SW-1:0]        slot_nxt;
    logic                 lr_nxt;

    assign sum        = {1'b0, acc} + {1'b0, inc_reg};
    assign inc_accept = inc_load && (inc_in != '0);
    // A pending carry while bclk is high means this edge produces a falling bclk.
    assign fall_now   = carry_q && bclk;

    always_comb begin
        bit_wrap = (bit_cnt == BW'(SLOT_BITS - 1));
        bit_nxt  = bit_wrap ? '0 : bit_cnt + 1'b1;
        slot_nxt = slot_idx;
        if (bit_wrap) begin
            slot_nxt = (slot_idx == SW'(CHANNELS - 1)) ? '0 : slot_idx + 1'b1;
        end
        if (MODE == 0) begin
            lr_nxt = ({1'b0, slot_nxt} >= LR_HALF);
        end else begin
            lr_nxt = (slot_nxt == '0) && (bit_nxt == '0);
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= IDLE;
            inc_reg     <= DEFAULT_INC;
            acc         <= '0;
            carry_q     <= 1'b0;
            bit_cnt     <= '0;
            slot_idx    <= '0;
            lock_cnt    <= '0;
            bclk        <= 1'b0;
            bclk_rise   <= 1'b0;
            bclk_fall   <= 1'b0;
            lrclk       <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
        end else begin
            if (inc_accept) begin
                inc_reg <= inc_in;
            end
            if (!enable) begin
                state       <= IDLE;
                acc         <= '0;
                carry_q     <= 1'b0;
                bit_cnt     <= '0;
                slot_idx    <= '0;
                lock_cnt    <= '0;
                bclk        <= 1'b0;
                bclk_rise   <= 1'b0;
                bclk_fall   <= 1'b0;
                lrclk       <= 1'b0;
                frame_start <= 1'b0;
                locked      <= 1'b0;
            end else if (state == IDLE) begin
                state <= WARMUP;
            end else begin
                acc         <= sum[ACC_WIDTH-1:0];
                carry_q     <= sum[ACC_WIDTH];
                bclk        <= bclk ^ carry_q;
                bclk_rise   <= carry_q && !bclk;
                bclk_fall   <= fall_now;
                frame_start <= 1'b0;
                if (fall_now) begin
                    bit_cnt     <= bit_nxt;
                    slot_idx    <= slot_nxt;
                    lrclk       <= lr_nxt;
                    frame_start <= (bit_nxt == '0) && (slot_nxt == '0);
                end
                // A new rate invalidates lock; frame phase keeps running.
                if (state == RUN && inc_accept) begin
                    state    <= WARMUP;
                    lock_cnt <= '0;
                    locked   <= 1'b0;
                end else if (state == WARMUP && bclk_rise) begin
                    lock_cnt <= lock_cnt + 1'b1;
                    if (lock_cnt == 8'(LOCK_CYCLES - 1)) begin
                        state  <= RUN;
                        locked <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_clkgen.sv
// Bench for i2s_clkgen: an I2S instance and a TDM instance share stimulus; a phase-sum
// model is compared every cycle, with directed literal checks on periods and lock timing.
module tb_i2s_clkgen;

    logic       refclk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] inc_in;
    logic       inc_load;

    logic bclk0, rise0, fall0, lr0, fs0, lock0;
    logic slot0;
    logic bclk1, rise1, fall1, lr1, fs1, lock1;
    logic [1:0] slot1;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    bit cmp_on   = 1'b0;

    always #5 refclk = ~refclk;

    i2s_clkgen #(.ACC_WIDTH(4), .DEFAULT_INC(4), .SLOT_BITS(16), .CHANNELS(2),
                 .MODE(0), .LOCK_CYCLES(16)) dut0 (
        .refclk(refclk), .rst(rst), .enable(enable), .inc_in(inc_in), .inc_load(inc_load),
        .bclk(bclk0), .bclk_rise(rise0), .bclk_fall(fall0), .lrclk(lr0),
        .slot_idx(slot0), .frame_start(fs0), .locked(lock0));

    i2s_clkgen #(.ACC_WIDTH(4), .DEFAULT_INC(4), .SLOT_BITS(8), .CHANNELS(4),
                 .MODE(1), .LOCK_CYCLES(16)) dut1 (
        .refclk(refclk), .rst(rst), .enable(enable), .inc_in(inc_in), .inc_load(inc_load),
        .bclk(bclk1), .bclk_rise(rise1), .bclk_fall(fall1), .lrclk(lr1),
        .slot_idx(slot1), .frame_start(fs1), .locked(lock1));

    // Model: total phase m_p (never wraps), half-periods elapsed m_h, state 0/1/2 = idle/warmup/run.
    longint unsigned m_p;
    int  m_inc, m_h, m_lock, m_st;
    bit  m_pend, m_rise, m_fall;

    always @(posedge refclk) begin
        bit prise, cap;
        prise  = m_rise;
        cap    = inc_load && (inc_in != 4'd0);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (rst) begin
            m_st = 0; m_inc = 4; m_p = 0; m_h = 0; m_pend = 0; m_lock = 0;
        end else begin
            if (!enable) begin
                m_st = 0; m_p = 0; m_h = 0; m_pend = 0; m_lock = 0;
            end else if (m_st == 0) begin
                m_st = 1;
            end else begin
                if (m_pend) begin
                    m_h++;
                    if (m_h % 2 == 1) m_rise = 1'b1;
                    else m_fall = 1'b1;
                end
                m_pend = ((m_p + longint'(m_inc)) >> 4) != (m_p >> 4);
                m_p    = m_p + longint'(m_inc);
                if (m_st == 2 && cap) begin
                    m_st = 1; m_lock = 0;
                end else if (m_st == 1 && prise) begin
                    m_lock++;
                    if (m_lock == 16) m_st = 2;
                end
            end
            if (cap) m_inc = int'(inc_in);
        end
    end

    // Outputs follow from the count of bclk falls F = m_h/2.
    function automatic logic [7:0] expect_out(input int sb, input int ch, input int mode);
        int f, slot, frame;
        logic lr, fs;
        f     = m_h / 2;
        frame = sb * ch;
        slot  = (f / sb) % ch;
        if (mode == 0) lr = (slot >= (ch + 1) / 2);
        else           lr = (f > 0) && (f % frame == 0);
        fs = m_fall && (f % frame == 0);
        return {logic'(m_h % 2), m_rise, m_fall, lr, fs, logic'(m_st == 2), 2'(slot)};
    endfunction

    function automatic logic [7:0] pack0();
        return {bclk0, rise0, fall0, lr0, fs0, lock0, 1'b0, slot0};
    endfunction

    function automatic logic [7:0] pack1();
        return {bclk1, rise1, fall1, lr1, fs1, lock1, slot1};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        vec_cnt++;
        if (act != exp) begin
            miss_cnt++;
            $display("FAIL %s at %0t: got %0d (0x%0h), want %0d (0x%0h)", name, $time, act, act, exp, exp);
        end
    endtask

    always @(negedge refclk) begin
        if (cmp_on) begin
            check("model_dut0", longint'(pack0()), longint'(expect_out(16, 2, 0)));
            check("model_dut1", longint'(pack1()), longint'(expect_out(8, 4, 1)));
        end
    end

    function automatic bit sig(input int sel);
        case (sel)
            0: return rise0;
            1: return fs0;
            2: return fall0;
            default: return slot0 == 1'b1;
        endcase
    endfunction

    // Waits (bounded) for an event; n = negedges elapsed until it is seen.
    task automatic wait_ev(input int sel, input int limit, output int n);
        n = 0;
        do begin
            @(negedge refclk);
            n++;
        end while (!sig(sel) && n < limit);
        if (!sig(sel)) begin
            vec_cnt++;
            miss_cnt++;
            $display("FAIL timeout_sel%0d at %0t: no event within %0d cycles", sel, $time, limit);
        end
    endtask

    initial begin
        int n, rises, code, prev;
        int lr0_hi, lr0_first, lr1_hi, lr1_early;

        rst = 1'b1; enable = 1'b0; inc_in = 4'd0; inc_load = 1'b0;
        repeat (3) @(negedge refclk);
        cmp_on = 1'b1;
        check("reset_out0", longint'(pack0()), 0);
        check("reset_out1", longint'(pack1()), 0);
        rst = 1'b0;
        repeat (3) @(negedge refclk);
        check("idle_out0", longint'(pack0()), 0);

        // Start-up: first rise 5 edges after enable is sampled, period 8, lock after 16 rises.
        enable = 1'b1;
        wait_ev(0, 50, n);
        check("first_rise_gap", n - 1, 5);
        wait_ev(0, 50, n);
        check("bclk_period_inc4", n, 8);
        rises = 2;
        while (rises < 16) begin
            wait_ev(0, 50, n);
            rises++;
        end
        check("locked_at_16th_rise", lock0, 0);
        @(negedge refclk);
        check("locked_after_16th_rise", lock0, 1);

        // One full frame starting at frame_start.
        wait_ev(1, 400, n);
        lr0_hi = 0; lr0_first = 0; lr1_hi = 0; lr1_early = 0; code = 1; prev = -1;
        for (int i = 0; i < 256; i++) begin
            if (lr0) begin lr0_hi++; if (i < 128) lr0_first++; end
            if (lr1) begin lr1_hi++; if (i < 8) lr1_early++; end
            if (int'(slot1) != prev) begin code = code * 10 + int'(slot1); prev = int'(slot1); end
            @(negedge refclk);
        end
        if (int'(slot1) != prev) code = code * 10 + int'(slot1);
        check("frame_interval_256", fs0, 1);
        check("lr0_high_cycles", lr0_hi, 128);
        check("lr0_low_first_half", lr0_first, 0);
        check("tdm_lr_high_cycles", lr1_hi, 8);
        check("tdm_lr_at_slot0_bit0", lr1_early, 8);
        check("tdm_lr_repeat_32bclk", lr1, 1);
        check("tdm_slot_sequence", code, 101230);

        // Rate change while locked.
        repeat (2) @(negedge refclk);
        inc_in = 4'd2; inc_load = 1'b1;
        @(negedge refclk);
        inc_load = 1'b0;
        check("locked_drop_on_load", lock0, 0);
        rises = 0;
        while (rises < 16) begin
            wait_ev(0, 100, n);
            rises++;
            if (rises == 4) check("bclk_period_inc2", n, 16);
        end
        check("relock_at_16th_rise", lock0, 0);
        @(negedge refclk);
        check("relock_after_16th_rise", lock0, 1);

        // Zero increment is ignored.
        inc_in = 4'd0; inc_load = 1'b1;
        @(negedge refclk);
        inc_load = 1'b0;
        @(negedge refclk);
        check("zero_inc_keeps_lock", lock0, 1);
        wait_ev(0, 100, n);
        wait_ev(0, 100, n);
        check("zero_inc_keeps_period", n, 16);

        // Disable mid-frame with a simultaneous load: outputs clear, increment still taken.
        repeat (37) @(negedge refclk);
        enable = 1'b0; inc_in = 4'd4; inc_load = 1'b1;
        @(negedge refclk);
        inc_load = 1'b0;
        check("disable_zero0", longint'(pack0()), 0);
        check("disable_zero1", longint'(pack1()), 0);
        repeat (4) @(negedge refclk);
        enable = 1'b1;
        wait_ev(0, 50, n);
        check("reenable_rise_gap", n - 1, 5);
        wait_ev(0, 50, n);
        check("reenable_period_inc4", n, 8);

        // Reset at slot 1, bit 5 restores DEFAULT_INC and restarts the frame.
        inc_in = 4'd2; inc_load = 1'b1;
        @(negedge refclk);
        inc_load = 1'b0;
        wait_ev(3, 1200, n);
        for (int k = 0; k < 5; k++) wait_ev(2, 40, n);
        rst = 1'b1;
        @(negedge refclk);
        rst = 1'b0;
        check("rst_mid_zero0", longint'(pack0()), 0);
        check("rst_mid_zero1", longint'(pack1()), 0);
        wait_ev(0, 50, n);
        check("rst_restart_rise_gap", n - 1, 5);
        check("rst_restart_slot0", slot0, 0);
        wait_ev(0, 50, n);
        check("rst_restart_period_default", n, 8);

        repeat (4) @(negedge refclk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/i2s_clkgen.md
I2S_CLKGEN -- requirements
Module: i2s_clkgen

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32, the phase accumulator width in bits (8..48).
REQ-002 SHALL have parameter DEFAULT_INC, default 242442314, the reset-time phase increment (about 1.4112 MHz bclk from 50 MHz).
REQ-003 SHALL have parameter SLOT_BITS, default 16, the bclk periods per channel slot (2..32).
REQ-004 SHALL have parameter CHANNELS, default 2, the slots per frame (1..16).
REQ-005 SHALL have parameter MODE, default 0, selecting the frame format: 0 = I2S (lrclk 50% duty), 1 = TDM (lrclk one-bclk pulse).
REQ-006 SHALL have parameter LOCK_CYCLES, default 16, the bclk rising edges counted before locked asserts (1..255).
REQ-007 SHALL have port refclk, input, 1 bit: the sole clock, all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port enable, input, 1 bit: run request.
REQ-010 SHALL have port inc_in, input, ACC_WIDTH bits: new phase increment.
REQ-011 SHALL have port inc_load, input, 1 bit: one-cycle strobe that captures inc_in.
REQ-012 SHALL have port bclk, output, 1 bit: generated bit clock, registered.
REQ-013 SHALL have port bclk_rise, output, 1 bit: one-refclk pulse in the cycle bclk goes 0->1.
REQ-014 SHALL have port bclk_fall, output, 1 bit: one-refclk pulse in the cycle bclk goes 1->0.
REQ-015 SHALL have port lrclk, output, 1 bit: frame/word select.
REQ-016 SHALL have port slot_idx, output, max(1,clog2(CHANNELS)) bits: current slot number.
REQ-017 SHALL have port frame_start, output, 1 bit: one-refclk pulse at the start of slot 0, bit 0.
REQ-018 SHALL have port locked, output, 1 bit: clocks are stable and valid.

Function
REQ-019 SHALL add inc_reg to acc every refclk cycle while in state WARMUP or RUN, wrapping modulo 2^ACC_WIDTH.
REQ-020 SHALL toggle bclk in the cycle after each acc carry-out, so that f_bclk = f_refclk*inc_reg/2^(ACC_WIDTH+1).
REQ-021 SHALL assert bclk_rise and bclk_fall in the same cycle as the corresponding bclk edge, each for exactly one cycle.
REQ-022 SHALL advance bit_cnt (0..SLOT_BITS-1) on each bclk falling edge, and advance slot_idx (0..CHANNELS-1) when bit_cnt wraps, with slot_idx wrapping from CHANNELS-1 to 0.
REQ-023 SHALL, in MODE 0, drive lrclk low for slots < ceil(CHANNELS/2) and high otherwise, with changes only on the bclk falling edge that begins bit 0 of a slot.
REQ-024 SHALL, in MODE 1, drive lrclk high for exactly the bclk period of slot 0, bit 0, and low otherwise.
REQ-025 SHALL pulse frame_start coincident with bclk_fall when the new position is slot 0, bit 0.
REQ-026 SHALL implement the FSM IDLE -> WARMUP -> RUN:
- IDLE -> WARMUP when enable=1.
- WARMUP -> RUN after LOCK_CYCLES bclk_rise pulses.
- WARMUP or RUN -> IDLE when enable=0.
- RUN -> WARMUP on an accepted inc_load, with the lock counter cleared.
REQ-027 SHALL drive locked=1 only in RUN, registered, and drop it in the cycle after the transition out of RUN.
REQ-028 SHALL, in IDLE, hold acc, bit_cnt, slot_idx and the lock counter at 0, and hold bclk, lrclk and all pulse outputs at 0.
REQ-029 SHALL, on inc_load=1 with inc_in != 0, update inc_reg at the next edge; the carry computed in that same cycle uses the old inc_reg.
REQ-030 SHALL ignore inc_load with inc_in = 0, leaving inc_reg and the state unchanged.
REQ-031 SHALL give enable=0 priority over a simultaneous inc_load; the increment is still captured if it is nonzero.
REQ-032 SHALL NOT reset acc or the frame counters on a RUN -> WARMUP transition, so the frame phase continues.

Reset
REQ-033 SHALL, while rst=1 at a refclk edge, set state IDLE, inc_reg=DEFAULT_INC, acc=0, bit_cnt=0, slot_idx=0, lock counter=0, and bclk=lrclk=bclk_rise=bclk_fall=frame_start=locked=0.
REQ-034 SHALL take rst precedence over enable and inc_load, and a mid-frame rst SHALL restart the frame at slot 0, bit 0 once enable is high.

Verification
REQ-035 SHALL cover this case (ACC_WIDTH=4, DEFAULT_INC=4): rst, then enable=1 -> bclk period of 8 refclk cycles, first bclk_rise 5 cycles after enable.
REQ-036 SHALL cover this case (same config, SLOT_BITS=16, CHANNELS=2, MODE=0): frame_start every 256 cycles; lrclk low for 128 cycles, then high for 128 cycles.
REQ-037 SHALL cover this case (LOCK_CYCLES=16): locked rises in the cycle after the 16th bclk_rise; inc_load with inc_in=2 drops locked next cycle, the bclk period becomes 16, and locked re-asserts after 16 further rises.
REQ-038 SHALL cover these cases: inc_load with inc_in=0 -> no change to period or locked; enable=0 mid-frame -> all outputs 0 next cycle.
REQ-039 SHALL cover this case (MODE=1, CHANNELS=4, SLOT_BITS=8): lrclk high for exactly 1 bclk period every 32 bclk periods; slot_idx sequence 0,1,2,3,0.
REQ-040 SHALL cover this case: rst asserted in slot 1, bit 5 -> outputs 0, then restart at slot 0, bit 0 with inc_reg=DEFAULT_INC.
